// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath, with retire counting and illegal-op flag.
// Outputs follow the registered state (0 cycles); en=0 stalls the FSM and masks all write/enable strobes.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_en,
  output logic        Branch,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        RegDst,
  output logic        regWrite,
  output logic        MemToReg,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [3:0]  state,
  output logic        retire,
  output logic [15:0] retired_cnt,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     cur_state;
  state_t     nxt_state;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       op_legal;
  logic       dec_illegal;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign op_legal    = (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
                       (op == OP_ADDI) || ((op == OP_RTYPE) && funct_ok);
  assign dec_illegal = (cur_state == S_DECODE) && !op_legal;

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        if (!op_legal)                       nxt_state = S_FETCH;
        else if (op == OP_LW || op == OP_SW) nxt_state = S_MEMADR;
        else if (op == OP_RTYPE)             nxt_state = S_EXEC;
        else if (op == OP_BEQ)               nxt_state = S_BRANCH;
        else                                 nxt_state = S_ADDIEX;
      end
      S_MEMADR: nxt_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt_state = S_MEMWB;
      S_EXEC:   nxt_state = S_ALUWB;
      S_ADDIEX: nxt_state = S_ADDIWB;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // State, counter and sticky flag all freeze together while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state   <= S_FETCH;
      retired_cnt <= 16'd0;
      illegal     <= 1'b0;
    end else if (en) begin
      cur_state <= nxt_state;
      if (retire)      retired_cnt <= retired_cnt + 16'd1;
      if (dec_illegal) illegal     <= 1'b1;
    end
  end

  assign state = cur_state;

  always_comb begin
    pc_en     = 1'b0;
    Branch    = 1'b0;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = ALU_AND;
    RegDst    = 1'b0;
    regWrite  = 1'b0;
    MemToReg  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    retire    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        MemRead   = 1'b1;
        i_or_d    = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        MemToReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        i_or_d    = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        retire    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu;
      end
      S_ALUWB: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu;
        regWrite  = 1'b1;
        RegDst    = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        Branch    = zero;
        pc_en     = zero;
        retire    = 1'b1;
      end
      S_ADDIWB: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        regWrite  = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase

    if (!en) begin
      pc_en    = 1'b0;
      ir_write = 1'b0;
      regWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      retire   = 1'b0;
    end

    // Reset blanks every decoded output immediately, not on the next edge.
    if (!rst) begin
      pc_en     = 1'b0;
      Branch    = 1'b0;
      ir_write  = 1'b0;
      i_or_d    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = ALU_AND;
      RegDst    = 1'b0;
      regWrite  = 1'b0;
      MemToReg  = 1'b0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stall, reset abort and counter wrap.
module tb_multicycle_control;

  logic        clk, rst, en, zero;
  logic [5:0]  op, funct;
  logic        pc_en, Branch, ir_write, i_or_d, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op, state;
  logic        RegDst, regWrite, MemToReg, MemWrite, MemRead, retire, illegal;
  logic [15:0] retired_cnt;
  logic [16:0] ctrl;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .Branch(Branch), .ir_write(ir_write), .i_or_d(i_or_d),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .RegDst(RegDst), .regWrite(regWrite), .MemToReg(MemToReg),
    .MemWrite(MemWrite), .MemRead(MemRead), .state(state), .retire(retire),
    .retired_cnt(retired_cnt), .illegal(illegal)
  );

  assign ctrl = {pc_en, Branch, ir_write, i_or_d, alu_src_a, alu_src_b, alu_op,
                 RegDst, regWrite, MemToReg, MemWrite, MemRead, retire};

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic pc, input logic br, input logic ir,
                                     input logic iod, input logic sa, input logic [1:0] sb,
                                     input logic [3:0] aop, input logic rd, input logic rw,
                                     input logic m2r, input logic mw, input logic mr,
                                     input logic ret);
    return {pc, br, ir, iod, sa, sb, aop, rd, rw, m2r, mw, mr, ret};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [16:0] c);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(c));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  logic [16:0] c_fetch, c_dec, c_madr, c_mrd, c_mwb, c_mwr, c_stall, c_aiex, c_aiwb, c_fstall;
  logic [5:0]  fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0]  ao_tab [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

  initial begin
    c_fetch  = mk(1,0,1,0,0,2'b01,ADD,  0,0,0,0,1,0);
    c_fstall = mk(0,0,0,0,0,2'b01,ADD,  0,0,0,0,0,0);
    c_dec    = mk(0,0,0,0,0,2'b11,ADD,  0,0,0,0,0,0);
    c_madr   = mk(0,0,0,0,1,2'b10,ADD,  0,0,0,0,0,0);
    c_mrd    = mk(0,0,0,1,1,2'b10,ADD,  0,0,0,0,1,0);
    c_mwb    = mk(0,0,0,0,0,2'b00,4'h0, 0,1,1,0,0,1);
    c_mwr    = mk(0,0,0,1,1,2'b10,ADD,  0,0,0,1,0,1);
    c_stall  = mk(0,0,0,1,1,2'b10,ADD,  0,0,0,0,0,0);
    c_aiex   = mk(0,0,0,0,1,2'b10,ADD,  0,0,0,0,0,0);
    c_aiwb   = mk(0,0,0,0,1,2'b10,ADD,  0,1,0,0,0,1);

    clk = 0; rst = 0; en = 1; op = 6'b0; funct = 6'b0; zero = 0;
    #3;
    step("reset", 4'd0, 17'd0);
    chk("reset.cnt", 32'(retired_cnt), 32'd0);
    chk("reset.illegal", 32'(illegal), 32'd0);

    // lw: 0,1,2,3,4 then back to FETCH
    @(negedge clk);
    rst = 1; op = 6'b100011;
    #1 step("lw.fetch", 4'd0, c_fetch);
    tick; step("lw.decode", 4'd1, c_dec);
    tick; step("lw.memadr", 4'd2, c_madr);
    tick; step("lw.memrd", 4'd3, c_mrd);
    tick; step("lw.memwb", 4'd4, c_mwb);
    tick; step("lw.done", 4'd0, c_fetch);
    chk("lw.cnt", 32'(retired_cnt), 32'd1);

    // every R-type funct, 4 cycles each
    for (int i = 0; i < 5; i++) begin
      op = 6'b000000; funct = fn_tab[i];
      tick; chk("r.decode", 32'(state), 32'd1);
      tick; step("r.exec", 4'd6, mk(0,0,0,0,1,2'b00,ao_tab[i],0,0,0,0,0,0));
      tick; step("r.aluwb", 4'd7, mk(0,0,0,0,1,2'b00,ao_tab[i],1,1,0,0,0,1));
      tick; chk("r.done", 32'(state), 32'd0);
      chk("r.cnt", 32'(retired_cnt), 32'(2 + i));
    end

    // beq taken and not taken
    op = 6'b000100; zero = 1;
    tick; tick; step("beq.taken", 4'd8, mk(1,1,0,0,1,2'b00,SUB,0,0,0,0,0,1));
    tick; chk("beq.taken.done", 32'(state), 32'd0);
    zero = 0;
    tick; tick; step("beq.fall", 4'd8, mk(0,0,0,0,1,2'b00,SUB,0,0,0,0,0,1));
    tick; chk("beq.cnt", 32'(retired_cnt), 32'd8);

    // unsupported opcode, then a valid addi
    op = 6'b111111;
    tick; step("ill.decode", 4'd1, c_dec);
    chk("ill.pre", 32'(illegal), 32'd0);
    tick; chk("ill.state", 32'(state), 32'd0);
    chk("ill.flag", 32'(illegal), 32'd1);
    chk("ill.cnt", 32'(retired_cnt), 32'd8);
    op = 6'b001000;
    tick; tick; step("addi.ex", 4'd9, c_aiex);
    tick; step("addi.wb", 4'd10, c_aiwb);
    tick; chk("addi.done", 32'(state), 32'd0);
    chk("addi.flag", 32'(illegal), 32'd1);
    chk("addi.cnt", 32'(retired_cnt), 32'd9);

    // stall in FETCH masks strobes
    en = 0;
    #1 step("fstall", 4'd0, c_fstall);
    tick; step("fstall.hold", 4'd0, c_fstall);
    en = 1;

    // sw stalled three cycles in MEMWR
    op = 6'b101011;
    tick; tick; step("sw.memadr", 4'd2, c_madr);
    tick; step("sw.memwr", 4'd5, c_mwr);
    en = 0;
    #1 step("sw.stall0", 4'd5, c_stall);
    for (int i = 0; i < 3; i++) begin
      tick; step("sw.stall", 4'd5, c_stall);
    end
    chk("sw.stall.cnt", 32'(retired_cnt), 32'd9);
    en = 1;
    #1 step("sw.resume", 4'd5, c_mwr);
    tick; step("sw.done", 4'd0, c_fetch);
    chk("sw.cnt", 32'(retired_cnt), 32'd10);

    // reset mid-ALUWB acts without a clock edge
    op = 6'b000000; funct = 6'b100000;
    tick; tick; tick; step("rab.aluwb", 4'd7, mk(0,0,0,0,1,2'b00,ADD,1,1,0,0,0,1));
    #2 rst = 0;
    #1 step("rab.reset", 4'd0, 17'd0);
    chk("rab.cnt", 32'(retired_cnt), 32'd0);
    chk("rab.flag", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1;
    #1 step("rab.fetch", 4'd0, c_fetch);

    // counter wrap from 0xFFFF on the next retire
    op = 6'b000100; zero = 0;
    tick; tick; chk("wrap.branch", 32'(state), 32'd8);
    force dut.retired_cnt = 16'hFFFF;
    #1 release dut.retired_cnt;
    tick; chk("wrap.state", 32'(state), 32'd0);
    chk("wrap.cnt", 32'(retired_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
